// File: rtl/sodor5_verif_checker_if.sv
// Stimulus/commit bundle shared by the lockstep checker and its driver.
// master drives instructions and observes commits; slave is the checker.
interface sodor5_verif_checker_if #(
    parameter int WORD_SIZE = 32
);
    logic [31:0]          instr;
    logic                 commit_valid;
    logic [4:0]           commit_rd;
    logic [WORD_SIZE-1:0] commit_data;
    logic                 mismatch;
    logic [31:0]          retire_count;

    modport master (
        output instr,
        input  commit_valid, commit_rd, commit_data, mismatch, retire_count
    );

    modport slave (
        input  instr,
        output commit_valid, commit_rd, commit_data, mismatch, retire_count
    );
endinterface

// File: rtl/sodor5_verif_checker.sv
// Lockstep OP-IMM checker: 5-stage forwarding pipeline vs single-cycle reference model.
// Optional macro REGFILE_CLEAR_EN: async reset also clears both register files.
module sodor5_verif_checker #(
    parameter int NUM_REGS  = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sodor5_verif_checker_if.slave   bus
);

    localparam logic [6:0]           OPC_OP_IMM = 7'b0010011;
    localparam logic [WORD_SIZE-1:0] ZERO_W     = '0;

    function automatic logic [WORD_SIZE-1:0] f_sext_imm(input logic [11:0] imm);
        return {{(WORD_SIZE-12){imm[11]}}, imm};
    endfunction

    function automatic logic [WORD_SIZE-1:0] f_alu(
        input logic [2:0]           f3,
        input logic [WORD_SIZE-1:0] a,
        input logic [WORD_SIZE-1:0] imm
    );
        logic [WORD_SIZE-1:0] res;
        res = '0;
        case (f3)
            3'd0: res = a + imm;
            3'd1: res = a << imm[4:0];
            3'd2: res = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(imm))};
            3'd3: res = {{(WORD_SIZE-1){1'b0}}, (a < imm)};
            3'd4: res = a ^ imm;
            3'd5: begin
                // kept as separate assignments so the arithmetic shift stays signed
                if (imm[10]) res = $signed(a) >>> imm[4:0];
                else         res = a >> imm[4:0];
            end
            3'd6: res = a | imm;
            default: res = a & imm;
        endcase
        return res;
    endfunction

    logic [WORD_SIZE-1:0] r_rf_pipe [NUM_REGS];
    logic [WORD_SIZE-1:0] r_rf_ref  [NUM_REGS];

    logic [31:0]          r_if_instr;

    logic                 r_ex_valid;
    logic [4:0]           r_ex_rd;
    logic [2:0]           r_ex_f3;
    logic [WORD_SIZE-1:0] r_ex_opa;
    logic [WORD_SIZE-1:0] r_ex_imm;

    logic                 r_mem_valid;
    logic [4:0]           r_mem_rd;
    logic [WORD_SIZE-1:0] r_mem_data;

    logic                 r_wb_valid;
    logic [4:0]           r_wb_rd;
    logic [WORD_SIZE-1:0] r_wb_data;

    logic                 r_commit_valid;
    logic [4:0]           r_commit_rd;
    logic [WORD_SIZE-1:0] r_commit_data;
    logic                 r_mismatch;
    logic [31:0]          r_retire_count;

    logic                 r_q_valid [4];
    logic [4:0]           r_q_rd    [4];
    logic [WORD_SIZE-1:0] r_q_data  [4];

    logic                 w_id_valid;
    logic [4:0]           w_id_rd;
    logic [2:0]           w_id_f3;
    logic [4:0]           w_id_rs1;
    logic [WORD_SIZE-1:0] w_id_imm;
    logic [WORD_SIZE-1:0] w_id_opa;
    logic [WORD_SIZE-1:0] w_ex_result;

    logic                 w_ref_valid;
    logic [4:0]           w_ref_rd;
    logic [4:0]           w_ref_rs1;
    logic [WORD_SIZE-1:0] w_ref_opa;
    logic [WORD_SIZE-1:0] w_ref_result;
    logic                 w_chk_bad;

    assign w_id_valid = (r_if_instr[6:0] == OPC_OP_IMM);
    assign w_id_rd    = r_if_instr[11:7];
    assign w_id_f3    = r_if_instr[14:12];
    assign w_id_rs1   = r_if_instr[19:15];
    assign w_id_imm   = f_sext_imm(r_if_instr[31:20]);

    // Invalid slots carry rd=0, so they never match a forwarding compare.
    assign w_ex_result = (r_ex_rd == 5'd0) ? ZERO_W : f_alu(r_ex_f3, r_ex_opa, r_ex_imm);

    // Youngest writer wins; the WB hit also covers the same-edge regfile write.
    always_comb begin
        w_id_opa = '0;
        if (w_id_rs1 != 5'd0) begin
            if (r_ex_valid && (r_ex_rd == w_id_rs1))
                w_id_opa = w_ex_result;
            else if (r_mem_valid && (r_mem_rd == w_id_rs1))
                w_id_opa = r_mem_data;
            else if (r_wb_valid && (r_wb_rd == w_id_rs1))
                w_id_opa = r_wb_data;
            else
                w_id_opa = r_rf_pipe[w_id_rs1];
        end
    end

    assign w_ref_valid  = (bus.instr[6:0] == OPC_OP_IMM);
    assign w_ref_rd     = bus.instr[11:7];
    assign w_ref_rs1    = bus.instr[19:15];
    assign w_ref_opa    = (w_ref_rs1 == 5'd0) ? ZERO_W : r_rf_ref[w_ref_rs1];
    assign w_ref_result = (!w_ref_valid || (w_ref_rd == 5'd0)) ? ZERO_W :
                          f_alu(bus.instr[14:12], w_ref_opa, f_sext_imm(bus.instr[31:20]));

    assign w_chk_bad = (r_wb_valid != r_q_valid[3]) ||
                       (r_wb_valid && ((r_wb_rd != r_q_rd[3]) || (r_wb_data != r_q_data[3])));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_if_instr     <= '0;
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_f3        <= '0;
            r_ex_opa       <= '0;
            r_ex_imm       <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_data     <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_mismatch     <= 1'b0;
            r_retire_count <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q_valid[i] <= 1'b0;
                r_q_rd[i]    <= '0;
                r_q_data[i]  <= '0;
            end
        end else begin
            r_if_instr <= bus.instr;

            r_ex_valid <= w_id_valid;
            r_ex_rd    <= w_id_valid ? w_id_rd : 5'd0;
            r_ex_f3    <= w_id_f3;
            r_ex_opa   <= w_id_opa;
            r_ex_imm   <= w_id_imm;

            r_mem_valid <= r_ex_valid;
            r_mem_rd    <= r_ex_rd;
            r_mem_data  <= r_ex_valid ? w_ex_result : ZERO_W;

            r_wb_valid <= r_mem_valid;
            r_wb_rd    <= r_mem_rd;
            r_wb_data  <= r_mem_data;

            r_commit_valid <= r_wb_valid;
            r_commit_rd    <= r_wb_rd;
            r_commit_data  <= r_wb_data;
            if (r_wb_valid)
                r_retire_count <= r_retire_count + 32'd1;
            if (w_chk_bad)
                r_mismatch <= 1'b1;

            r_q_valid[0] <= w_ref_valid;
            r_q_rd[0]    <= w_ref_valid ? w_ref_rd : 5'd0;
            r_q_data[0]  <= w_ref_result;
            for (int i = 1; i < 4; i++) begin
                r_q_valid[i] <= r_q_valid[i-1];
                r_q_rd[i]    <= r_q_rd[i-1];
                r_q_data[i]  <= r_q_data[i-1];
            end
        end
    end

`ifdef REGFILE_CLEAR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf_pipe[i] <= '0;
                r_rf_ref[i]  <= '0;
            end
        end else begin
            if (r_wb_valid && (r_wb_rd != 5'd0))
                r_rf_pipe[r_wb_rd] <= r_wb_data;
            if (w_ref_valid && (w_ref_rd != 5'd0))
                r_rf_ref[w_ref_rd] <= w_ref_result;
        end
    end
`else
    // No reset on the arrays: contents survive reset and must be preloaded.
    always_ff @(posedge clk) begin
        if (r_wb_valid && (r_wb_rd != 5'd0))
            r_rf_pipe[r_wb_rd] <= r_wb_data;
        if (reset_n && w_ref_valid && (w_ref_rd != 5'd0))
            r_rf_ref[w_ref_rd] <= w_ref_result;
    end
`endif

    assign bus.commit_valid = r_commit_valid;
    assign bus.commit_rd    = r_commit_rd;
    assign bus.commit_data  = r_commit_data;
    assign bus.mismatch     = r_mismatch;
    assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_sodor5_verif_checker.sv
// Directed and seeded-random bench for sodor5_verif_checker; expected values come from
// hand-computed constants and a small architectural model kept in the bench.
module tb_sodor5_verif_checker;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sodor5_verif_checker_if #(.WORD_SIZE(32)) bus ();

    sodor5_verif_checker #(.NUM_REGS(32), .WORD_SIZE(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_rf [32];
    logic [4:0]  e_rd   [200];
    logic [31:0] e_data [200];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] opimm(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [11:0] imm12);
        logic [31:0] imm;
        logic [31:0] r;
        imm = {{20{imm12[11]}}, imm12};
        r = 32'd0;
        case (f3)
            3'd0: r = a + imm;
            3'd1: r = a << imm12[4:0];
            3'd2: r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            3'd3: r = (a < imm) ? 32'd1 : 32'd0;
            3'd4: r = a ^ imm;
            3'd5: begin
                if (imm12[10]) r = $signed(a) >>> imm12[4:0];
                else           r = a >> imm12[4:0];
            end
            3'd6: r = a | imm;
            default: r = a & imm;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [31:0] i);
        bus.instr = i;
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        dut.r_rf_pipe[idx] = val;
        dut.r_rf_ref[idx]  = val;
        m_rf[idx]          = val;
    endtask

    task automatic expect_commit(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, "_valid"}, {31'd0, bus.commit_valid}, 32'd1);
        chk({tag, "_rd"},    {27'd0, bus.commit_rd},    {27'd0, rd});
        chk({tag, "_data"},  bus.commit_data,           data);
    endtask

    initial begin
        logic [31:0] ins;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1;
        logic [11:0] imm;
        logic [31:0] a, r;
        logic [31:0] exp_rf;

        bus.instr = NOP;
        repeat (2) @(negedge clk);

        chk("rst_valid",  {31'd0, bus.commit_valid}, 32'd0);
        chk("rst_rd",     {27'd0, bus.commit_rd},    32'd0);
        chk("rst_data",   bus.commit_data,           32'd0);
        chk("rst_mism",   {31'd0, bus.mismatch},     32'd0);
        chk("rst_retire", bus.retire_count,          32'd0);

        for (int i = 0; i < 32; i++) preload(i, 32'd0);
        preload(1, 32'h0000_0005);
        preload(5, 32'h8000_0000);
        reset_n = 1'b1;

        // ADDI x2,x1,-1; commit must not appear before the fourth edge
        issue(32'hFFF0_8113);
        repeat (3) issue(NOP);
        chk("lat_early", {31'd0, bus.commit_valid}, 32'd0);
        issue(NOP);
        expect_commit("addi", 5'd2, 32'h0000_0004);
        chk("addi_mism", {31'd0, bus.mismatch}, 32'd0);

        // dependency chain through EX, MEM and WB forwarding
        issue(opimm(3'd0, 5'd3, 5'd0, 12'd7));
        issue(opimm(3'd0, 5'd3, 5'd3, 12'd1));
        issue(opimm(3'd0, 5'd3, 5'd3, 12'd1));
        repeat (2) issue(NOP);
        expect_commit("chain0", 5'd3, 32'd7);
        issue(NOP);
        expect_commit("chain1", 5'd3, 32'd8);
        issue(NOP);
        expect_commit("chain2", 5'd3, 32'd9);

        issue(opimm(3'd5, 5'd4, 5'd5, 12'h404));
        issue(opimm(3'd5, 5'd4, 5'd5, 12'h004));
        repeat (3) issue(NOP);
        expect_commit("srai", 5'd4, 32'hF800_0000);
        issue(NOP);
        expect_commit("srli", 5'd4, 32'h0800_0000);

        issue(opimm(3'd3, 5'd6, 5'd0, 12'hFFF));
        issue(opimm(3'd2, 5'd6, 5'd0, 12'hFFF));
        repeat (3) issue(NOP);
        expect_commit("sltiu", 5'd6, 32'd1);
        issue(NOP);
        expect_commit("slti", 5'd6, 32'd0);

        // rd=0 still retires with zero data
        issue(opimm(3'd0, 5'd0, 5'd1, 12'd5));
        repeat (4) issue(NOP);
        expect_commit("rd0", 5'd0, 32'd0);
        chk("dir_retire", bus.retire_count, 32'd9);
        chk("dir_mism", {31'd0, bus.mismatch}, 32'd0);

        // random stream with random preload
        reset_n = 1'b0;
        bus.instr = NOP;
        @(negedge clk);
        chk("rst2_retire", bus.retire_count, 32'd0);
        preload(0, 32'd0);
        for (int i = 1; i < 32; i++) preload(i, $urandom);
        reset_n = 1'b1;

        for (int c = 0; c < 204; c++) begin
            ins = NOP;
            if (c < 200) begin
                f3  = 3'($urandom_range(0, 7));
                rd  = 5'($urandom_range(0, 31));
                rs1 = 5'($urandom_range(0, 31));
                imm = 12'($urandom);
                if (f3 == 3'd1) imm = {7'b0, imm[4:0]};
                if (f3 == 3'd5) imm = {1'b0, 1'($urandom_range(0, 1)), 5'b0, imm[4:0]};
                ins = opimm(f3, rd, rs1, imm);
                a = (rs1 == 5'd0) ? 32'd0 : m_rf[rs1];
                r = (rd == 5'd0) ? 32'd0 : m_alu(f3, a, imm);
                if (rd != 5'd0) m_rf[rd] = r;
                e_rd[c]   = rd;
                e_data[c] = r;
            end
            issue(ins);
            if (c >= 4) begin
                chk("rnd_valid", {31'd0, bus.commit_valid}, 32'd1);
                chk("rnd_rd",    {27'd0, bus.commit_rd},    {27'd0, e_rd[c-4]});
                chk("rnd_data",  bus.commit_data,           e_data[c-4]);
            end
        end
        chk("rnd_retire", bus.retire_count, 32'd200);
        chk("rnd_mism", {31'd0, bus.mismatch}, 32'd0);

        // reset mid-stream: I0,I1 commit, I2..I5 are dropped
        for (int k = 0; k < 6; k++)
            issue(opimm(3'd0, 5'(10 + k), 5'd0, 12'(100 + k)));
        chk("pre_rst_retire", bus.retire_count, 32'd202);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid",  {31'd0, bus.commit_valid}, 32'd0);
        chk("mid_rst_retire", bus.retire_count,          32'd0);
        bus.instr = NOP;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 10; k < 16; k++) begin
`ifdef REGFILE_CLEAR_EN
            exp_rf = 32'd0;
`else
            exp_rf = (k < 12) ? 32'(90 + k) : m_rf[k];
`endif
            chk($sformatf("drop_x%0d", k), dut.r_rf_pipe[k], exp_rf);
        end

        issue(opimm(3'd0, 5'd20, 5'd0, 12'd5));
        repeat (3) issue(NOP);
        chk("post_rst_early", {31'd0, bus.commit_valid}, 32'd0);
        issue(NOP);
        expect_commit("post_rst", 5'd20, 32'd5);
        chk("post_rst_retire", bus.retire_count, 32'd1);
        chk("post_rst_mism", {31'd0, bus.mismatch}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sodor5_verif_checker.md
Name: sodor5_verif_checker

Overview:
- Lockstep verification block that executes the same RISC-V OP-IMM instruction stream on two engines and compares them every retire:
  - a 5-stage pipelined datapath (IF/ID/EX/MEM/WB) with full forwarding;
  - a single-cycle architectural reference model.
- Sits between the instruction stimulus source and the bench scoreboard.
- Reports per-retire commit data and a sticky mismatch flag.

Parameters:
- NUM_REGS, 32, architectural registers per register file (x0 hardwired to zero).
- WORD_SIZE, 32, datapath and register width in bits.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- instr  input  32  fetched instruction; one valid instruction per cycle, no handshake.
- commit_valid  output  1  WB stage retires an instruction this cycle.
- commit_rd  output  5  destination register of the retiring instruction.
- commit_data  output  32  value written by the pipeline at WB.
- mismatch  output  1  sticky; set on the first pipeline/model disagreement.
- retire_count  output  32  number of retired instructions since reset.

Behaviour:
- Reset (reset_n=0, asynchronous): all pipeline stages hold bubbles; expected-result queue emptied.
  - commit_valid=0, commit_rd=0, commit_data=0, mismatch=0, retire_count=0.
  - Register files are not reset (see Optional Feature).
- Decode: instr[6:0]=7'b0010011 is OP-IMM; any other opcode is a NOP (no write, no retire).
  - rd=instr[11:7], funct3=instr[14:12], rs1=instr[19:15], imm=sign-extended instr[31:20].
- funct3 operations:
  - 0 ADDI: add, wraps mod 2^32.
  - 2 SLTI: signed compare, result 1/0.
  - 3 SLTIU: unsigned compare against the sign-extended imm, result 1/0.
  - 4 XORI, 6 ORI, 7 ANDI: bitwise.
  - 1 SLLI: shift left by imm[4:0].
  - 5 SRLI/SRAI: logical right shift by imm[4:0]; arithmetic if imm[10]=1.
  - Other imm[11:5] bits are ignored for shifts.
- Pipeline timing: instr sampled at edge N; ID N+1, EX N+2, MEM N+3. The WB register-file write and commit outputs are registered at edge N+4. Fixed latency of 4 cycles, 1 instruction per cycle, no stalls.
- Forwarding: the ID operand read takes the youngest in-flight writer to the same rs1, priority EX > MEM > WB, then the register file. Register-file write and read in the same cycle is write-first.
- x0: reads return 0; writes with rd=0 are discarded in both engines.
  - A valid OP-IMM with rd=0 still retires: commit_valid=1, commit_data=0.
- Reference model:
  - On each non-reset edge it executes the sampled instr against its own register file immediately.
  - It pushes {valid, rd, result} into a 4-deep delay queue aligned with WB.
- Checker: when commit_valid=1, compare commit_rd and commit_data with the queue head.
  - Any difference sets mismatch; mismatch clears only on reset.
  - A valid bit that disagrees between the engines also sets mismatch.
- retire_count increments on every commit_valid and wraps at 2^32.
- Reset mid-stream: in-flight instructions are dropped with no writes. After release, the first commit appears exactly 4 cycles after the first sampled OP-IMM.

Optional Feature:
- REGFILE_CLEAR_EN:
  - Defined: asynchronous reset clears every entry of both register files to 0.
  - Undefined: neither register file is reset. The bench must preload identical values into both files by hierarchical assignment before releasing reset, otherwise the first read of an unwritten register is X.

Test Plan:
- Preload x1=0x00000005, issue ADDI x2,x1,-1 (0xFFF08113) → 4 cycles later commit_rd=2, commit_data=0x00000004, mismatch=0.
- Back-to-back dependency chain ADDI x3,x0,7; ADDI x3,x3,1; ADDI x3,x3,1 → commits 7, 8, 9 on consecutive cycles, exercising forwarding from EX, MEM and WB.
- SRAI x4,x5,4 with x5=0x80000000 → commit_data=0xF8000000; SRLI with the same operands → 0x08000000.
- SLTIU x6,x0,-1 → commit_data=1; SLTI x6,x0,-1 → commit_data=0.
- Stream of 200 random OP-IMM instructions with random regfile preload (shift immediates masked to legal forms) → retire_count=200, mismatch=0.
- Assert reset_n low mid-stream for 1 cycle → commit_valid=0 and retire_count=0 immediately; no register-file writes from dropped instructions; first new commit exactly 4 cycles after release.
